scmem_io: RTL and testbench

- Data-side responder for the single-cycle CPU's memory port.
- The CPU drives the address (ALU result), write data and write enable; this block returns read data in the same cycle.
- Decodes the address into two regions: a word RAM, and a small MMIO window holding a GPIO register, a cycle counter and a byte TX FIFO.
- The TX FIFO drains to an external valid/ready consumer, such as a future UART transmitter.

---
 rtl/scmem_io_pkg.sv | 28 ++
 rtl/scmem_io_tx_fifo.sv | 55 +++++
 rtl/scmem_io.sv | 95 +++++++++
 tb/tb_scmem_io.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/scmem_io_pkg.sv
// Shared constants for the scmem_io data-memory responder: region select,
// MMIO word selects and STATUS register bit layout.
package scmem_io_pkg;

    localparam int IO_SEL_BIT = 31;

    localparam logic [5:0] OFF_GPIO   = 6'h00;
    localparam logic [5:0] OFF_CYCLE  = 6'h01;
    localparam logic [5:0] OFF_TXDATA = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;

    localparam int ST_EMPTY  = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_CNT_LO = 4;

    function automatic logic [31:0] make_status(input logic empty, input logic full,
                                                input logic ovf, input logic [3:0] cnt);
        logic [31:0] s;
        s = '0;
        s[ST_EMPTY] = empty;
        s[ST_FULL] = full;
        s[ST_OVF] = ovf;
        s[ST_CNT_LO +: 4] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/scmem_io_tx_fifo.sv
// Byte FIFO feeding the TX consumer; pointers wrap modulo DEPTH (power of 2).
// A push while full is accepted only when a pop frees the head slot the same cycle.
module tx_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    // NOTE: storage has no reset; emptiness is tracked by count alone, so a
    // reset-free array keeps it a plain RAM instead of a flop bank.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every block
    // sees pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scmem_io.sv
// Data-side memory responder for the single-cycle CPU: word RAM plus an MMIO
// window (GPIO, cycle counter, TX FIFO, STATUS) with zero-latency reads.
module scmem_io
    import scmem_io_pkg::*;
#(
    parameter int RAM_AW     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic [31:0] gpio_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]       ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic [5:0]        sel;
    logic              is_io;
    logic [31:0]       cycle;
    logic              ovf;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              tx_push;
    logic              tx_pop;
    logic              ovf_set;
    logic              ovf_clr;
    logic              unused_addr;

    assign is_io   = addr[IO_SEL_BIT];
    assign sel     = addr[7:2];
    assign ram_idx = addr[RAM_AW+1:2];
    assign unused_addr = &{1'b0, addr[30:8], addr[1:0]};

    assign tx_push = we & is_io & (sel == OFF_TXDATA);
    assign tx_pop  = tx_valid & tx_ready;
    assign ovf_set = tx_push & fifo_full & ~tx_pop;
    assign ovf_clr = we & is_io & (sel == OFF_STATUS) & wdata[ST_OVF];
    assign tx_valid = ~fifo_empty;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (tx_push),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (tx_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (we && !is_io) ram[ram_idx] <= wdata;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            gpio_out <= '0;
            cycle    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (we && is_io && sel == OFF_GPIO) gpio_out <= wdata;
            // A load replaces the increment for that cycle.
            if (we && is_io && sel == OFF_CYCLE) cycle <= wdata;
            else                                 cycle <= cycle + 32'd1;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // NOTE: rdata gets a default first so no path through the case infers a latch.
    always_comb begin
        rdata = '0;
        if (!is_io) begin
            rdata = ram[ram_idx];
        end else begin
            case (sel)
                OFF_GPIO:   rdata = gpio_out;
                OFF_CYCLE:  rdata = cycle;
                OFF_STATUS: rdata = make_status(fifo_empty, fifo_full, ovf, 4'(fifo_count));
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_scmem_io.sv
// Directed self-checking bench for scmem_io: RAM, GPIO, counter, TX FIFO and reset.
module tb_scmem_io;

    localparam logic [31:0] A_GPIO   = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;
    localparam logic [31:0] A_UNDEF  = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int passed = 0;
    int total  = 0;

    scmem_io #(.RAM_AW(5), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Store spanning one clock edge; returns 1 time unit after the edge with we low.
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; we = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clrn = 1'b0; addr = '0; wdata = '0; we = 1'b0; tx_ready = 1'b0;
        #2;
        check("rst_gpio", gpio_out, 32'h0);
        check("rst_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_txdata", {24'b0, tx_data}, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0000_0001);
        @(negedge clk);
        clrn = 1'b1;

        // RAM write, read and alias
        store(32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_alias", 32'h0000_0090, 32'hDEAD_BEEF);
        @(negedge clk);
        addr = 32'h0000_0010; wdata = 32'h1234_5678; we = 1'b1;
        #1;
        check("ram_same_cycle", rdata, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("ram_after_edge", rdata, 32'h1234_5678);

        // GPIO and undefined offset
        store(A_GPIO, 32'h0000_00A5);
        check("gpio_out", gpio_out, 32'h0000_00A5);
        read_check("gpio_rd", A_GPIO, 32'h0000_00A5);
        read_check("undef_rd", A_UNDEF, 32'h0);
        read_check("txdata_rd", A_TXDATA, 32'h0);
        store(A_UNDEF, 32'hFFFF_FFFF);
        check("undef_wr_gpio", gpio_out, 32'h0000_00A5);
        read_check("undef_wr_status", A_STATUS, 32'h0000_0001);
        read_check("undef_wr_ram", 32'h0000_0010, 32'h1234_5678);

        // Counter load and wrap
        store(A_CYCLE, 32'hFFFF_FFFE);
        read_check("cyc_load", A_CYCLE, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("cyc_plus1", rdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("cyc_wrap", rdata, 32'h0000_0000);

        // FIFO fill and overflow
        tx_ready = 1'b0;
        store(A_TXDATA, 32'h11);
        store(A_TXDATA, 32'h22);
        store(A_TXDATA, 32'h33);
        store(A_TXDATA, 32'h44);
        read_check("fifo_full_status", A_STATUS, 32'h0000_0040 | 32'h2);
        store(A_TXDATA, 32'h55);
        read_check("fifo_ovf_status", A_STATUS, 32'h0000_0046);
        check("fifo_head", {24'b0, tx_data}, 32'h11);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check("drain0", {23'b0, tx_valid, tx_data}, 32'h111);
        @(negedge clk);
        check("drain1", {23'b0, tx_valid, tx_data}, 32'h122);
        @(negedge clk);
        check("drain2", {23'b0, tx_valid, tx_data}, 32'h133);
        @(negedge clk);
        check("drain3", {23'b0, tx_valid, tx_data}, 32'h144);
        @(negedge clk);
        check("drain_empty", {23'b0, tx_valid, tx_data}, 32'h000);
        tx_ready = 1'b0;
        read_check("ovf_sticky", A_STATUS, 32'h0000_0005);
        store(A_STATUS, 32'h0000_0004);
        read_check("ovf_cleared", A_STATUS, 32'h0000_0001);

        // Full FIFO with simultaneous push and pop
        store(A_TXDATA, 32'h71);
        store(A_TXDATA, 32'h72);
        store(A_TXDATA, 32'h73);
        store(A_TXDATA, 32'h74);
        @(negedge clk);
        addr = A_TXDATA; wdata = 32'h66; we = 1'b1; tx_ready = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; tx_ready = 1'b0;
        read_check("pp_status", A_STATUS, 32'h0000_0042);
        check("pp_head", {24'b0, tx_data}, 32'h72);
        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check("pp_drain0", {23'b0, tx_valid, tx_data}, 32'h172);
        @(negedge clk);
        check("pp_drain1", {23'b0, tx_valid, tx_data}, 32'h173);
        @(negedge clk);
        check("pp_drain2", {23'b0, tx_valid, tx_data}, 32'h174);
        @(negedge clk);
        check("pp_drain3", {23'b0, tx_valid, tx_data}, 32'h166);
        @(negedge clk);
        check("pp_empty", {23'b0, tx_valid, tx_data}, 32'h000);
        tx_ready = 1'b0;

        // Reset mid-run with a queued byte and a pending push
        store(A_TXDATA, 32'h99);
        check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        @(negedge clk);
        addr = A_TXDATA; wdata = 32'hAA; we = 1'b1;
        #2;
        clrn = 1'b0;
        #1;
        check("mid_rst_gpio", gpio_out, 32'h0);
        check("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
        check("mid_rst_txdata", {24'b0, tx_data}, 32'h0);
        we = 1'b0;
        read_check("mid_rst_status", A_STATUS, 32'h0000_0001);
        read_check("mid_rst_cycle", A_CYCLE, 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'b0, tx_valid}, 32'h0);
        read_check("post_rst_status", A_STATUS, 32'h0000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
